// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: 8-level priority interrupt sequencer with a
// two-pulse INTA acknowledge, in-service tracking and EOI handling.
// Optional feature macro: INTERRUPT_ROTATE_EN. When it is defined, an
// accepted EOI with eoi_rotate = 1 rotates priority. When it is not
// defined, the lowest-priority level stays fixed at LOWEST_PRIO_RST.
module interrupt_sequencer #(
  parameter logic [2:0] LOWEST_PRIO_RST = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       eoi_rotate,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [7:0] irr_clear,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [1:0] ack_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_GAP  = 2'd2,
    ST_ACK2 = 2'd3
  } state_t;

  // Registered state
  state_t     r_state;
  logic [2:0] r_lowest_prio;
  logic [7:0] r_isr;
  logic       r_inta_prev;
  logic [2:0] r_w;          // level being acknowledged
  logic       r_spurious;   // acknowledge started with no winner
  logic       r_int_out;
  logic [7:0] r_irr_clear;
  logic [7:0] r_data_out;
  logic       r_data_oe;
  logic [1:0] r_ack_count;

  // Priority resolution
  logic [7:0] w_pending;
  logic [2:0] w_lvl_of_rank [8];  // level that currently holds each rank
  logic [7:0] w_pend_rank;        // pending requests, indexed by rank
  logic [7:0] w_isr_rank;         // in-service bits, indexed by rank
  logic       w_isr_hit;
  logic [2:0] w_isr_top_rank;
  logic [2:0] w_isr_top_lvl;
  logic [3:0] w_rank_limit;
  logic       w_win_valid;
  logic [2:0] w_win_lvl;

  // Acknowledge / EOI control
  logic       w_fall;
  logic       w_rise;
  state_t     w_state_next;
  logic       w_take;
  logic [7:0] w_set_mask;
  logic [7:0] w_auto_clr;
  logic       w_eoi_acc;
  logic [2:0] w_eoi_lvl;
  logic [7:0] w_eoi_clr;
  logic [7:0] w_isr_next;

  assign w_pending = irr & ~imr;

  // Rank r is held by level (lowest_prio + 1 + r) mod 8, so rank 0 sits
  // just above the lowest-priority level.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rank
      assign w_lvl_of_rank[gi] = r_lowest_prio + 3'd1 + 3'(gi);
      assign w_pend_rank[gi]   = w_pending[w_lvl_of_rank[gi]];
      assign w_isr_rank[gi]    = r_isr[w_lvl_of_rank[gi]];
    end
  endgenerate

  // Find the highest-ranked in-service level (smallest rank index wins).
  always_comb begin
    w_isr_hit      = 1'b0;
    w_isr_top_rank = 3'd0;
    w_isr_top_lvl  = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_isr_rank[k]) begin
        w_isr_hit      = 1'b1;
        w_isr_top_rank = 3'(k);
        w_isr_top_lvl  = w_lvl_of_rank[k];
      end
    end
  end

  // A request only wins if it outranks everything already in service.
  assign w_rank_limit = w_isr_hit ? {1'b0, w_isr_top_rank} : 4'd8;

  // Pick the best pending request that is below the in-service limit.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_lvl   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_pend_rank[k] && (4'(k) < w_rank_limit)) begin
        w_win_valid = 1'b1;
        w_win_lvl   = w_lvl_of_rank[k];
      end
    end
  end

  // INTA edges are judged against last cycle's sample.
  assign w_fall = r_inta_prev & ~inta_n;
  assign w_rise = ~r_inta_prev & inta_n;

  // Next-state decode for the two-pulse acknowledge handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_fall) w_state_next = ST_ACK1;
      ST_ACK1: if (w_rise) w_state_next = ST_GAP;
      ST_GAP:  if (w_fall) w_state_next = ST_ACK2;
      ST_ACK2: if (w_rise) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_take     = (r_state == ST_IDLE) && w_fall;
  assign w_set_mask = (w_take && w_win_valid) ? (8'd1 << w_win_lvl) : 8'd0;
  assign w_auto_clr = ((r_state == ST_ACK2) && w_rise && auto_eoi && !r_spurious)
                      ? (8'd1 << r_w) : 8'd0;

  // EOI is disabled entirely in automatic-EOI mode; a non-specific EOI
  // with nothing in service is dropped so it cannot rotate priority.
  assign w_eoi_acc = eoi_valid && !auto_eoi && (eoi_specific || w_isr_hit);
  assign w_eoi_lvl = eoi_specific ? eoi_level : w_isr_top_lvl;
  assign w_eoi_clr = w_eoi_acc ? (8'd1 << w_eoi_lvl) : 8'd0;

  // Clears are applied first so a same-cycle set on the same bit wins.
  assign w_isr_next = (r_isr & ~(w_eoi_clr | w_auto_clr)) | w_set_mask;

  // Previous INTA sample for edge detection; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inta_prev <= 1'b1;
    end else begin
      r_inta_prev <= inta_n;
    end
  end

  // Acknowledge FSM with registered bus outputs and the IRR clear pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_w         <= 3'd7;
      r_spurious  <= 1'b0;
      r_irr_clear <= 8'd0;
      r_data_out  <= 8'd0;
      r_data_oe   <= 1'b0;
      r_ack_count <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_irr_clear <= w_set_mask;
      if (w_take) begin
        r_w        <= w_win_valid ? w_win_lvl : 3'd7;
        r_spurious <= !w_win_valid;
      end
      case (w_state_next)
        ST_ACK2: begin
          r_data_out  <= {vector_base, r_w};
          r_data_oe   <= 1'b1;
          r_ack_count <= 2'd2;
        end
        ST_ACK1, ST_GAP: begin
          r_data_out  <= 8'd0;
          r_data_oe   <= 1'b0;
          r_ack_count <= 2'd1;
        end
        default: begin
          r_data_out  <= 8'd0;
          r_data_oe   <= 1'b0;
          r_ack_count <= 2'd0;
        end
      endcase
    end
  end

  // Request line to the CPU, raised only while no acknowledge is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_out <= 1'b0;
    end else begin
      r_int_out <= (r_state == ST_IDLE) && w_win_valid;
    end
  end

  // In-service register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_isr <= 8'd0;
    end else begin
      r_isr <= w_isr_next;
    end
  end

`ifdef INTERRUPT_ROTATE_EN
  // Rotation: the level just retired by EOI becomes the lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lowest_prio <= LOWEST_PRIO_RST;
    end else if (w_eoi_acc && eoi_rotate) begin
      r_lowest_prio <= w_eoi_lvl;
    end
  end
`else
  // Fixed priority: the lowest-priority level never moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lowest_prio <= LOWEST_PRIO_RST;
    end else begin
      r_lowest_prio <= LOWEST_PRIO_RST;
    end
  end

  logic w_unused_rotate;
  assign w_unused_rotate = eoi_rotate;
`endif

  assign int_out   = r_int_out;
  assign isr       = r_isr;
  assign irr_clear = r_irr_clear;
  assign data_out  = r_data_out;
  assign data_oe   = r_data_oe;
  assign ack_count = r_ack_count;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: a table of single
// acknowledge transactions plus hand-written multi-cycle sequences.
// Expected vectors are queued when an acknowledge starts and are
// compared when the DUT drives the bus in ACK2.
module tb_interrupt_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] irr;
  logic [7:0] imr;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       eoi_rotate;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] irr_clear;
  logic [7:0] data_out;
  logic       data_oe;
  logic [1:0] ack_count;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] exp_q[$];

  interrupt_sequencer #(.LOWEST_PRIO_RST(3'd7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irr          (irr),
    .imr          (imr),
    .inta_n       (inta_n),
    .vector_base  (vector_base),
    .auto_eoi     (auto_eoi),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .eoi_rotate   (eoi_rotate),
    .int_out      (int_out),
    .isr          (isr),
    .irr_clear    (irr_clear),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .ack_count    (ack_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] irr;
    logic [7:0] imr;
    logic [4:0] vb;
    logic       exp_int;
    logic [7:0] exp_clear;
    logic [7:0] exp_data;
    logic [7:0] exp_isr;
  } vec_t;

  vec_t vecs[6];

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    irr          = 8'h00;
    imr          = 8'h00;
    inta_n       = 1'b1;
    vector_base  = 5'h00;
    auto_eoi     = 1'b0;
    eoi_valid    = 1'b0;
    eoi_specific = 1'b0;
    eoi_level    = 3'd0;
    eoi_rotate   = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Full two-pulse acknowledge with checks in every phase.
  task automatic do_ack(input logic [7:0] exp_clear, input logic [7:0] exp_data,
                        input logic [7:0] exp_isr_ack2, input logic [7:0] exp_isr_after,
                        input logic eoi_at_fall, input logic [2:0] eoi_lvl);
    logic [7:0] want;
    exp_q.push_back(exp_data);
    inta_n = 1'b0;
    if (eoi_at_fall) begin
      eoi_valid    = 1'b1;
      eoi_specific = 1'b1;
      eoi_level    = eoi_lvl;
    end
    cyc();
    eoi_valid    = 1'b0;
    eoi_specific = 1'b0;
    check("ack1_count", {6'd0, ack_count}, 8'd1);
    check("ack1_irr_clear", irr_clear, exp_clear);
    check("ack1_oe", {7'd0, data_oe}, 8'd0);
    irr    = irr & ~exp_clear;
    inta_n = 1'b1;
    cyc();
    check("gap_count", {6'd0, ack_count}, 8'd1);
    check("gap_irr_clear_pulse", irr_clear, 8'h00);
    inta_n = 1'b0;
    cyc();
    check("ack2_count", {6'd0, ack_count}, 8'd2);
    check("ack2_oe", {7'd0, data_oe}, 8'd1);
    check("ack2_isr", isr, exp_isr_ack2);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL ack2_scoreboard: got empty queue expected an entry");
    end else begin
      want = exp_q.pop_front();
      check("ack2_data_out", data_out, want);
    end
    inta_n = 1'b1;
    cyc();
    check("idle_count", {6'd0, ack_count}, 8'd0);
    check("idle_oe", {7'd0, data_oe}, 8'd0);
    check("idle_data_out", data_out, 8'h00);
    check("idle_isr", isr, exp_isr_after);
    $display("ack: vector %h expected, isr now %h", exp_data, isr);
  endtask

  task automatic do_eoi(input logic spec, input logic [2:0] lvl, input logic rot);
    eoi_valid    = 1'b1;
    eoi_specific = spec;
    eoi_level    = lvl;
    eoi_rotate   = rot;
    cyc();
    eoi_valid    = 1'b0;
    eoi_specific = 1'b0;
    eoi_rotate   = 1'b0;
  endtask

  initial begin
    //          irr    imr    vb     int   clear  data   isr
    vecs[0] = '{8'h24, 8'h00, 5'h10, 1'b1, 8'h04, 8'h82, 8'h04};
    vecs[1] = '{8'hFF, 8'h01, 5'h1F, 1'b1, 8'h02, 8'hF9, 8'h02};
    vecs[2] = '{8'h80, 8'h00, 5'h00, 1'b1, 8'h80, 8'h07, 8'h80};
    vecs[3] = '{8'h0F, 8'h0F, 5'h05, 1'b0, 8'h00, 8'h2F, 8'h00};
    vecs[4] = '{8'h00, 8'h00, 5'h0A, 1'b0, 8'h00, 8'h57, 8'h00};
    vecs[5] = '{8'hC0, 8'h40, 5'h13, 1'b1, 8'h80, 8'h9F, 8'h80};

    // Reset state, checked while reset is held.
    rst_n = 1'b0;
    irr = 8'h00; imr = 8'h00; inta_n = 1'b1; vector_base = 5'h00;
    auto_eoi = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0;
    eoi_level = 3'd0; eoi_rotate = 1'b0;
    cyc();
    check("rst_int_out", {7'd0, int_out}, 8'd0);
    check("rst_isr", isr, 8'h00);
    check("rst_irr_clear", irr_clear, 8'h00);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_oe", {7'd0, data_oe}, 8'd0);
    check("rst_ack_count", {6'd0, ack_count}, 8'd0);

    // Table of single acknowledges from a clean state.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      irr         = vecs[i].irr;
      imr         = vecs[i].imr;
      vector_base = vecs[i].vb;
      cyc();
      cyc();
      check("tbl_int_out", {7'd0, int_out}, {7'd0, vecs[i].exp_int});
      do_ack(vecs[i].exp_clear, vecs[i].exp_data, vecs[i].exp_isr, vecs[i].exp_isr, 1'b0, 3'd0);
    end

    // Nesting: lower-priority request held off, higher one accepted.
    do_reset();
    vector_base = 5'h01;
    irr = 8'h04;
    cyc(); cyc();
    do_ack(8'h04, 8'h0A, 8'h04, 8'h04, 1'b0, 3'd0);
    irr = 8'h08;
    cyc(); cyc();
    check("nest_low_int_out", {7'd0, int_out}, 8'd0);
    irr = 8'h02;
    cyc(); cyc();
    check("nest_high_int_out", {7'd0, int_out}, 8'd1);
    do_ack(8'h02, 8'h09, 8'h06, 8'h06, 1'b0, 3'd0);

    // EOI handling: non-specific, specific, then a no-op non-specific.
    do_eoi(1'b0, 3'd0, 1'b0);
    check("eoi_nonspec_isr", isr, 8'h04);
    do_eoi(1'b1, 3'd2, 1'b0);
    check("eoi_spec_isr", isr, 8'h00);
    do_eoi(1'b0, 3'd0, 1'b1);
    check("eoi_empty_isr", isr, 8'h00);
    irr = 8'h03;
    vector_base = 5'h00;
    cyc(); cyc();
    do_ack(8'h01, 8'h00, 8'h01, 8'h01, 1'b0, 3'd0);

    // EOI ignored in automatic-EOI mode.
    auto_eoi = 1'b1;
    do_eoi(1'b0, 3'd0, 1'b0);
    check("eoi_ignored_isr", isr, 8'h01);
    auto_eoi = 1'b0;

    // Automatic EOI clears the bit on the final rising edge.
    do_reset();
    auto_eoi = 1'b1;
    irr = 8'h01;
    vector_base = 5'h02;
    cyc(); cyc();
    do_ack(8'h01, 8'h10, 8'h01, 8'h00, 1'b0, 3'd0);
    auto_eoi = 1'b0;

    // Same-cycle set and specific EOI on the same level: set wins.
    do_reset();
    irr = 8'h04;
    vector_base = 5'h03;
    cyc(); cyc();
    do_ack(8'h04, 8'h1A, 8'h04, 8'h04, 1'b1, 3'd2);

    // Spurious acknowledge: request vanishes before the first pulse.
    do_reset();
    vector_base = 5'h1E;
    cyc();
    do_ack(8'h00, 8'hF7, 8'h00, 8'h00, 1'b0, 3'd0);

    // Reset asserted during GAP aborts the acknowledge at once.
    do_reset();
    irr = 8'h01;
    cyc(); cyc();
    inta_n = 1'b0;
    cyc();
    inta_n = 1'b1;
    cyc();
    check("gap_pre_count", {6'd0, ack_count}, 8'd1);
    check("gap_pre_isr", isr, 8'h01);
    rst_n = 1'b0;
    #2;
    check("gap_rst_isr", isr, 8'h00);
    check("gap_rst_oe", {7'd0, data_oe}, 8'd0);
    check("gap_rst_count", {6'd0, ack_count}, 8'd0);
    irr = 8'h00;
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    check("gap_post_isr", isr, 8'h00);
    check("gap_post_irr_clear", irr_clear, 8'h00);
    check("gap_post_int_out", {7'd0, int_out}, 8'd0);
    check("gap_post_count", {6'd0, ack_count}, 8'd0);

    // Rotating EOI: with rotation IR0 becomes lowest, so IR1 wins next.
    do_reset();
    irr = 8'h01;
    cyc(); cyc();
    do_ack(8'h01, 8'h00, 8'h01, 8'h01, 1'b0, 3'd0);
    do_eoi(1'b0, 3'd0, 1'b1);
    check("rot_eoi_isr", isr, 8'h00);
    irr = 8'h03;
    cyc(); cyc();
    check("rot_int_out", {7'd0, int_out}, 8'd1);
`ifdef INTERRUPT_ROTATE_EN
    do_ack(8'h02, 8'h01, 8'h02, 8'h02, 1'b0, 3'd0);
`else
    do_ack(8'h01, 8'h00, 8'h01, 8'h01, 1'b0, 3'd0);
`endif

    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have parameter LOWEST_PRIO_RST, default 3'd7, meaning the lowest-priority IR level loaded at reset (IR0 highest by default).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; one clock domain.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: irr  in  8  latched pending requests; imr  in  8  mask, 1 = masked.
REQ-005 SHALL have ports: inta_n  in  1  CPU acknowledge, active-low, synchronous to clk.
REQ-006 SHALL have ports: vector_base  in  5  vector bits T7..T3; auto_eoi  in  1  automatic EOI mode.
REQ-007 SHALL have ports: eoi_valid  in  1  one-cycle EOI strobe; eoi_specific  in  1; eoi_level  in  3; eoi_rotate  in  1.
REQ-008 SHALL have ports: int_out  out  1  interrupt request to CPU; isr  out  8  in-service register.
REQ-009 SHALL have ports: irr_clear  out  8  one-hot one-cycle pulse clearing the acknowledged IRR bit.
REQ-010 SHALL have ports: data_out  out  8  vector; data_oe  out  1  bus drive enable; ack_count  out  2  number of INTA pulses taken.

Function
REQ-011 SHALL hold 3-bit lowest_prio; rank(L) = (L - lowest_prio - 1) mod 8, rank 0 highest.
REQ-012 SHALL define winner as the unmasked irr bit (irr & ~imr) of lowest rank whose rank is strictly below the rank of the highest-ranked isr bit (any rank if isr = 0).
REQ-013 SHALL register int_out: 1 in the cycle after a winner exists while state = IDLE; 0 otherwise.
REQ-014 SHALL detect inta_n edges against a registered previous sample (reset value 1).
REQ-015 SHALL implement FSM IDLE -> ACK1 (inta_n falling) -> GAP (inta_n rising) -> ACK2 (inta_n falling) -> IDLE (inta_n rising).
REQ-016 SHALL, on the IDLE->ACK1 edge, latch winner level w, set isr[w], and pulse irr_clear[w] for exactly one cycle.
REQ-017 SHALL, if no winner exists at IDLE->ACK1 (spurious), latch w = 7, leave isr and irr_clear unchanged.
REQ-018 SHALL drive data_out = {vector_base, w} and data_oe = 1 only while in ACK2; data_out = 8'h00 otherwise.
REQ-019 SHALL drive ack_count = 0 in IDLE, 1 in ACK1/GAP, 2 in ACK2.
REQ-020 SHALL, on ACK2->IDLE with auto_eoi = 1 and non-spurious ack, clear isr[w].
REQ-021 SHALL accept eoi_valid in any state: non-specific clears the highest-ranked isr bit; specific clears isr[eoi_level].
REQ-022 SHALL treat non-specific EOI with isr = 0 as a no-op (no rotation).
REQ-023 SHALL give set priority when an EOI and a REQ-016 set target the same bit in one cycle.
REQ-024 SHALL ignore eoi_valid when auto_eoi = 1.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force state IDLE, isr 0, int_out 0, irr_clear 0, data_out 0, data_oe 0, ack_count 0, lowest_prio LOWEST_PRIO_RST.
REQ-026 SHALL abandon any acknowledge sequence in progress on reset with no ISR or IRR side effects after release.

Configuration
REQ-027 SHALL compile priority rotation only when macro INTERRUPT_ROTATE_EN is defined.
REQ-028 SHALL, with INTERRUPT_ROTATE_EN, load lowest_prio with the cleared level on an accepted EOI with eoi_rotate = 1.
REQ-029 SHALL, without INTERRUPT_ROTATE_EN, hold lowest_prio at LOWEST_PRIO_RST permanently and ignore eoi_rotate.

Verification
REQ-030 SHALL cover: irr=8'h24, imr=0, vector_base=5'h10, two INTA pulses -> int_out=1, isr=8'h04, irr_clear=8'h04 one cycle, data_out=8'h82 in ACK2.
REQ-031 SHALL cover: isr=8'h04, irr=8'h08 -> int_out stays 0; irr=8'h02 -> int_out=1, ack sets isr=8'h06.
REQ-032 SHALL cover: irr=0 during first INTA pulse -> isr unchanged, data_out={vector_base,3'd7}.
REQ-033 SHALL cover: auto_eoi=1, irr=8'h01 -> isr=8'h01 during ACK2, 8'h00 after second rising edge.
REQ-034 SHALL cover (INTERRUPT_ROTATE_EN): isr=8'h01, non-specific EOI with eoi_rotate=1 -> isr=0, lowest_prio=0; irr=8'h03 -> winner IR1.
REQ-035 SHALL cover: rst_n low during GAP -> state IDLE, data_oe=0, isr=0 immediately.
